// File: rtl/noc_tg_pkg.sv
// Shared definitions for the NoC traffic generator: destination patterns, FSM states,
// LFSR taps and the (x,y) header packing helper.
package noc_tg_pkg;

    localparam int unsigned PAT_RANDOM    = 0;
    localparam int unsigned PAT_TRANSPOSE = 1;
    localparam int unsigned PAT_BITCOMP   = 2;

    typedef enum logic [1:0] {
        StIdle,
        StGap,
        StSend,
        StDone
    } tg_state_e;

    // x^16 + x^14 + x^13 + x^11 + 1, one-based taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [31:0] pack_hdr(input logic [31:0] x, input logic [31:0] y,
                                             input int unsigned xs);
        return (y << xs) | x;
    endfunction

endpackage

// File: rtl/tg_lfsr16.sv
// Seedable 16-bit Fibonacci LFSR that advances one step whenever en is high.
module tg_lfsr16
    import noc_tg_pkg::*;
#(
    parameter logic [15:0] SEED = 16'h0001
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    output logic [15:0] lfsr
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr <= SEED;
        end else if (en) begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/traffic_gen_pe.sv
// Synthetic traffic source/sink for one NoC PE: rate-limited packet injection and latency sink.
// Define PE_LATENCY_STATS_EN to add latencyMax/latencyLast outputs and a per-receive log line.
module traffic_gen_pe
    import noc_tg_pkg::*;
#(
    parameter int unsigned X          = 8,
    parameter int unsigned Y          = 8,
    parameter int unsigned x_size     = $clog2(X),
    parameter int unsigned y_size     = $clog2(Y),
    parameter int unsigned data_width = 32,
    parameter int unsigned PE_X       = 0,
    parameter int unsigned PE_Y       = 0,
    parameter int unsigned numPackets = 100,
    parameter int unsigned rate       = 1,
    parameter int unsigned pat        = PAT_RANDOM,
    parameter logic [15:0] SEED       = 16'hACE1
`ifdef PE_LATENCY_STATS_EN
    ,
    parameter integer      LOG_FD     = 1
`endif
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 start,
    input  logic                                 enableSend,
    output logic                                 r_valid_pe,
    output logic [x_size+y_size+data_width-1:0]  r_data_pe,
    input  logic                                 r_ready_pe,
    input  logic                                 w_valid_pe,
    input  logic [x_size+y_size+data_width-1:0]  w_data_pe,
    output logic                                 done,
    output logic [31:0]                          receiveCount,
    output logic [31:0]                          latencySum
`ifdef PE_LATENCY_STATS_EN
    ,
    output logic [data_width-x_size-y_size-1:0]  latencyMax,
    output logic [data_width-x_size-y_size-1:0]  latencyLast
`endif
);

    localparam int unsigned HdrW = x_size + y_size;
    localparam int unsigned TS   = data_width - HdrW;
    localparam int unsigned Gap  = (rate > 1) ? rate - 1 : 0;

    localparam logic [x_size-1:0] SelfX    = x_size'(PE_X);
    localparam logic [y_size-1:0] SelfY    = y_size'(PE_Y);
    localparam logic [15:0]       SeedMix  = SEED ^ 16'(pack_hdr(PE_X, PE_Y, x_size));
    localparam logic [15:0]       LfsrSeed = (SeedMix == 16'd0) ? 16'd1 : SeedMix;

    tg_state_e     state_q;
    logic [31:0]   sent_q;
    logic [31:0]   gap_q;
    logic [TS-1:0] cycle_q;
    logic [15:0]   lfsr_val;
    logic          go, accept, last_pkt, launch;
    logic [31:0]   rnd_x, rnd_y, dst_x, dst_y;
    logic [HdrW-1:0] dest_hdr;
    logic [TS-1:0] rx_ts, rx_lat;
    logic          unused_bits;

    tg_lfsr16 #(
        .SEED (LfsrSeed)
    ) u_lfsr (
        .clk  (clk),
        .rstn (rstn),
        .en   (launch),
        .lfsr (lfsr_val)
    );

    assign go       = start && enableSend;
    assign accept   = r_valid_pe && r_ready_pe;
    assign last_pkt = (sent_q == numPackets - 1);

    always_comb begin
        rnd_x = 32'(lfsr_val[x_size-1:0]);
        rnd_y = 32'(lfsr_val[HdrW-1:x_size]);
        if (rnd_x >= X) rnd_x = rnd_x - X;
        if (rnd_y >= Y) rnd_y = rnd_y - Y;
        if (rnd_x == PE_X && rnd_y == PE_Y) rnd_x = (PE_X + 1) % X;
        dst_x = rnd_x;
        dst_y = rnd_y;
        if (pat == PAT_BITCOMP) begin
            dst_x = X - 1 - PE_X;
            dst_y = Y - 1 - PE_Y;
        end else if (pat == PAT_TRANSPOSE && PE_X != PE_Y) begin
            dst_x = PE_Y;
            dst_y = PE_X;
        end
        dest_hdr = HdrW'(pack_hdr(dst_x, dst_y, x_size));
    end

    // A launch loads a new packet; with rate=1 it bypasses GAP entirely.
    always_comb begin
        launch = 1'b0;
        unique case (state_q)
            StIdle:  launch = go && (sent_q < numPackets) && (Gap == 0);
            StGap:   launch = (gap_q == Gap - 1);
            StSend:  launch = accept && !last_pkt && go && (Gap == 0);
            default: launch = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            sent_q     <= '0;
            gap_q      <= '0;
            r_valid_pe <= 1'b0;
            r_data_pe  <= '0;
            done       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (go && sent_q < numPackets) begin
                        state_q <= StGap;
                        gap_q   <= '0;
                    end
                end
                StGap: gap_q <= gap_q + 32'd1;
                StSend: begin
                    if (accept) begin
                        sent_q     <= sent_q + 32'd1;
                        r_valid_pe <= 1'b0;
                        if (last_pkt) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else if (go) begin
                            state_q <= StGap;
                            gap_q   <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StDone: begin
                    if (!start) begin
                        state_q <= StIdle;
                        sent_q  <= '0;
                        done    <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (launch) begin
                state_q    <= StSend;
                r_valid_pe <= 1'b1;
                r_data_pe  <= {SelfY, SelfX, cycle_q, dest_hdr};
            end
        end
    end

    assign rx_ts  = w_data_pe[HdrW +: TS];
    assign rx_lat = cycle_q - rx_ts;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cycle_q      <= '0;
            receiveCount <= '0;
            latencySum   <= '0;
        end else begin
            cycle_q <= cycle_q + TS'(1);
            if (w_valid_pe) begin
                if (receiveCount != '1) receiveCount <= receiveCount + 32'd1;
                latencySum <= latencySum + 32'(rx_lat);
            end
        end
    end

`ifdef PE_LATENCY_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            latencyMax  <= '0;
            latencyLast <= '0;
        end else if (w_valid_pe) begin
            latencyLast <= rx_lat;
            if (rx_lat > latencyMax) latencyMax <= rx_lat;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rstn && w_valid_pe) begin
            $display("%0d:%0d,%0d:%0d,%0d,%0d,%0d",
                     w_data_pe[data_width-y_size +: x_size], w_data_pe[data_width +: y_size],
                     w_data_pe[x_size-1:0], w_data_pe[HdrW-1:x_size], rx_ts, cycle_q, rx_lat);
        end
    end
`endif
`endif

    assign unused_bits = ^{lfsr_val, w_data_pe};

endmodule
